// File: rtl/capsense_csd_prs_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : capsense_csd_prs_gen_if
//  Description : Control/strobe bundle between the CSD sequencer and the
//                pulse/precharge generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface capsense_csd_prs_gen_if #(
    parameter int PRESCALE_W = 8,
    parameter int LFSR_W     = 8
);
    logic                  enable;
    logic [PRESCALE_W-1:0] period;
    logic [LFSR_W-1:0]     seed;
    logic                  seed_load;
    logic                  pulse;
    logic                  prech;
    logic                  running;

    modport master (
        output enable, period, seed, seed_load,
        input  pulse, prech, running
    );

    modport slave (
        input  enable, period, seed, seed_load,
        output pulse, prech, running
    );
endinterface
`default_nettype wire

// File: rtl/capsense_csd_prs_gen.sv
`default_nettype none
// ============================================================================
//  Module      : capsense_csd_prs_gen
//  Description : Prescaled one-cycle pulse strobe for the CSD measurement
//                channel plus sensor precharge drive. With the macro
//                CAPSENSE_PRS_SPREAD_EN defined, prech follows a Galois LFSR
//                (spread spectrum); otherwise prech is a divided square wave
//                and the LFSR is not built.
//  Revision    : 1.0 - initial release
// ============================================================================
module capsense_csd_prs_gen #(
    parameter int PRESCALE_W = 8,
    parameter int LFSR_W     = 8    // 8 or 16
) (
    input  wire                   op_clock,
    input  wire                   reset,
    capsense_csd_prs_gen_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_pulse;
    logic                  r_prech;
    logic                  r_running;

    logic                  w_advance;
    logic                  w_prech_adv;

    // A strobe (and LFSR step) happens only on a terminal count in RUN that
    // is neither cancelled by a disable nor overridden by a seed load.
    assign w_advance = (r_state == ST_RUN) && bus.enable && !bus.seed_load &&
                       (r_cnt == '0);

`ifdef CAPSENSE_PRS_SPREAD_EN
    localparam logic [LFSR_W-1:0] c_TAPS = (LFSR_W == 16) ? LFSR_W'(16'hB400)
                                                           : LFSR_W'(8'hB8);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [LFSR_W-1:0] w_seed_val;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_TAPS : '0);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign w_seed_val  = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
    assign w_prech_adv = w_lfsr_next[0];

    // LFSR: seeded on request, stepped once per strobe, held otherwise so the
    // sequence resumes where it left off after a disable.
    always_ff @(posedge op_clock) begin
        if (reset) begin
            r_lfsr <= LFSR_W'(1);
        end else if (bus.seed_load) begin
            r_lfsr <= w_seed_val;
        end else if (w_advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    // Plain divider: precharge toggles on every strobe.
    assign w_prech_adv = ~r_prech;
`endif

    // Sequencer: prescaler down-counter, state and all registered outputs.
    always_ff @(posedge op_clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
            r_prech   <= 1'b0;
            r_running <= 1'b0;
        end else if (bus.seed_load) begin
            // Restart the prescaler without touching the state.
            r_cnt     <= bus.period;
            r_pulse   <= 1'b0;
            r_running <= (r_state == ST_RUN);
            if (r_state == ST_IDLE) begin
                r_prech <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= bus.period;
                    r_pulse   <= 1'b0;
                    r_prech   <= 1'b0;
                    r_running <= 1'b0;
                    if (bus.enable) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        // Disable wins over a coincident reload.
                        r_state   <= ST_IDLE;
                        r_pulse   <= 1'b0;
                        r_prech   <= 1'b0;
                        r_running <= 1'b0;
                    end else begin
                        r_running <= 1'b1;
                        if (w_advance) begin
                            r_cnt   <= bus.period;
                            r_pulse <= 1'b1;
                            r_prech <= w_prech_adv;
                        end else begin
                            r_cnt   <= r_cnt - PRESCALE_W'(1);
                            r_pulse <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pulse   = r_pulse;
    assign bus.prech   = r_prech;
    assign bus.running = r_running;

endmodule
`default_nettype wire
